// File: rtl/vga_color_mixer.sv
// VGA pixel colour output stage: selects cursor/letter/background masks, applies them to the tone
// word, blanks outside active video and keeps hsync/vsync aligned with the two-stage colour path.
module vga_color_mixer #(
   parameter int RB           = 3,
   parameter int GB           = 3,
   parameter int BB           = 2,
   parameter int BLINK_FRAMES = 30
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [RB+GB+BB-1:0]   ton,
   input  logic                  letra,
   input  logic                  cursor,
   input  logic                  blank,
   input  logic                  hsync_in,
   input  logic                  vsync_in,
   input  logic [2:0]            color_p,
   input  logic [2:0]            color_l,
   input  logic [2:0]            color_c,
   input  logic [1:0]            mode,
   output logic [RB-1:0]         rojo,
   output logic [GB-1:0]         verde,
   output logic [BB-1:0]         azul,
   output logic                  hsync_out,
   output logic                  vsync_out,
   output logic                  blink_phase
);

   localparam int TW = RB + GB + BB;
   localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

   typedef enum logic [1:0] {
      MODE_NORMAL  = 2'b00,
      MODE_SWAP    = 2'b01,
      MODE_BLINK   = 2'b10,
      MODE_REVERSE = 2'b11
   } mode_e;

   mode_e           mode_q, mode_d;
   logic            vs_prev_q, vs_prev_d;
   logic [7:0]      blink_cnt_q, blink_cnt_d;
   logic            blink_phase_q, blink_phase_d;

   logic [2:0]      mask_q, mask_d;
   logic [TW-1:0]   ton_q, ton_d;
   logic            blank_q, blank_d;
   logic            hs1_q, hs1_d;
   logic            vs1_q, vs1_d;

   logic [RB-1:0]   rojo_q, rojo_d;
   logic [GB-1:0]   verde_q, verde_d;
   logic [BB-1:0]   azul_q, azul_d;
   logic            hs2_q, hs2_d;
   logic            vs2_q, vs2_d;

   logic            frame_edge;
   logic            cursor_vis;
   logic [2:0]      sel_mask;

   // Mode and blink state only move on the falling edge of vsync, so a frame is never split.
   always_comb begin
      frame_edge    = vs_prev_q & ~vsync_in;
      vs_prev_d     = vsync_in;
      mode_d        = mode_q;
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      if (frame_edge) begin
         mode_d = mode_e'(mode);
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = 8'd0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 8'd1;
         end
      end

      cursor_vis = cursor & ((mode_q != MODE_BLINK) | blink_phase_q);
      if (cursor_vis) begin
         sel_mask = color_c;
      end else if (letra ^ (mode_q == MODE_SWAP)) begin
         sel_mask = color_l;
      end else begin
         sel_mask = color_p;
      end
      mask_d  = (mode_q == MODE_REVERSE) ? ~sel_mask : sel_mask;
      ton_d   = ton;
      blank_d = blank;
      hs1_d   = hsync_in;
      vs1_d   = vsync_in;

      rojo_d  = (mask_q[0] & ~blank_q) ? ton_q[RB-1:0]        : '0;
      verde_d = (mask_q[1] & ~blank_q) ? ton_q[RB+GB-1:RB]    : '0;
      azul_d  = (mask_q[2] & ~blank_q) ? ton_q[TW-1:RB+GB]    : '0;
      hs2_d   = hs1_q;
      vs2_d   = vs1_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q        <= MODE_NORMAL;
         vs_prev_q     <= 1'b1;
         blink_cnt_q   <= 8'd0;
         blink_phase_q <= 1'b1;
         mask_q        <= 3'b000;
         ton_q         <= '0;
         blank_q       <= 1'b1;
         hs1_q         <= 1'b1;
         vs1_q         <= 1'b1;
         rojo_q        <= '0;
         verde_q       <= '0;
         azul_q        <= '0;
         hs2_q         <= 1'b1;
         vs2_q         <= 1'b1;
      end else begin
         mode_q        <= mode_d;
         vs_prev_q     <= vs_prev_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         mask_q        <= mask_d;
         ton_q         <= ton_d;
         blank_q       <= blank_d;
         hs1_q         <= hs1_d;
         vs1_q         <= vs1_d;
         rojo_q        <= rojo_d;
         verde_q       <= verde_d;
         azul_q        <= azul_d;
         hs2_q         <= hs2_d;
         vs2_q         <= vs2_d;
      end
   end

   assign rojo        = rojo_q;
   assign verde       = verde_q;
   assign azul        = azul_q;
   assign hsync_out   = hs2_q;
   assign vsync_out   = vs2_q;
   assign blink_phase = blink_phase_q;

endmodule
